// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard unit: tracks destination registers in flight after ID,
// selects forwarding sources, and interlocks on load-use (or on any RAW hazard without forwarding).
module pipe_hazard_unit #(
  parameter int NREG_AW    = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_EN     = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               id_valid,
  input  logic [NREG_AW-1:0] id_rs,
  input  logic [NREG_AW-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               id_wreg,
  input  logic [NREG_AW-1:0] id_wn,
  input  logic               id_m2reg,
  input  logic               redirect,
  output logic               stall,
  output logic               flush,
  output logic [2:0]         fwd_a,
  output logic [2:0]         fwd_b,
  output logic [15:0]        stall_cnt
);

  // Scoreboard: stage 1 is EX, stage DEPTH is WB.
  logic [DEPTH:1]     v;
  logic [DEPTH:1]     ld;
  logic [NREG_AW-1:0] wn [1:DEPTH];

  logic [DEPTH:1] hit_a;
  logic [DEPTH:1] hit_b;
  logic [2:0]     sel_a;
  logic [2:0]     sel_b;
  logic           ld_haz_a;
  logic           ld_haz_b;
  logic           any_early;
  logic           stall_req;

  always_comb begin
    // NOTE: every variable gets a default before any conditional logic, so no latch is inferred.
    hit_a     = '0;
    hit_b     = '0;
    sel_a     = '0;
    sel_b     = '0;
    ld_haz_a  = 1'b0;
    ld_haz_b  = 1'b0;
    any_early = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      hit_a[k] = id_valid && id_use_rs && v[k] && (wn[k] == id_rs) && (id_rs != '0);
      hit_b[k] = id_valid && id_use_rt && v[k] && (wn[k] == id_rt) && (id_rt != '0);
    end
    // Scan oldest to youngest so the last assignment is the youngest producer.
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit_a[k]) begin
        sel_a    = 3'(k);
        ld_haz_a = ld[k] && (k < LOAD_STAGE);
      end
      if (hit_b[k]) begin
        sel_b    = 3'(k);
        ld_haz_b = ld[k] && (k < LOAD_STAGE);
      end
      if ((k < DEPTH) && (hit_a[k] || hit_b[k])) any_early = 1'b1;
    end
  end

  // Without forwarding only a producer already in WB is visible through the register file.
  assign stall_req = (FWD_EN != 0) ? (ld_haz_a || ld_haz_b) : any_early;
  assign stall     = stall_req && !redirect;
  assign flush     = redirect;
  assign fwd_a     = (FWD_EN != 0) ? sel_a : 3'd0;
  assign fwd_b     = (FWD_EN != 0) ? sel_b : 3'd0;

  always_ff @(posedge clk) begin
    if (clrn) begin
      // NOTE: the destination fields are reset too; they are a few flops and this keeps X out of the comparators.
      v         <= '0;
      ld        <= '0;
      stall_cnt <= '0;
      for (int k = 1; k <= DEPTH; k++) wn[k] <= '0;
    end else begin
      // NOTE: non-blocking updates let each stage take its neighbour's pre-edge value regardless of loop order.
      for (int k = DEPTH; k >= 2; k--) begin
        v[k]  <= v[k-1];
        wn[k] <= wn[k-1];
        ld[k] <= ld[k-1];
      end
      if (!stall && !redirect) begin
        v[1]  <= id_valid && id_wreg && (id_wn != '0);
        wn[1] <= id_wn;
        ld[1] <= id_m2reg;
      end else begin
        v[1]  <= 1'b0;
        wn[1] <= '0;
        ld[1] <= 1'b0;
      end
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: three configurations of pipe_hazard_unit share one stimulus stream
// and are compared every cycle against a queue-based reference model, plus literal pins.
module tb_pipe_hazard_unit;

  localparam int NC = 3;
  localparam int CD [NC]  = '{3, 3, 5};
  localparam int CLS [NC] = '{2, 2, 3};
  localparam int CFW [NC] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       clrn;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic       redirect;

  logic        stall_o [NC];
  logic        flush_o [NC];
  logic [2:0]  fwd_a_o [NC];
  logic [2:0]  fwd_b_o [NC];
  logic [15:0] cnt_o   [NC];

  always #5 clk = ~clk;

  pipe_hazard_unit #(.NREG_AW(5), .DEPTH(3), .LOAD_STAGE(2), .FWD_EN(1)) u0 (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wn(id_wn),
    .id_m2reg(id_m2reg), .redirect(redirect), .stall(stall_o[0]), .flush(flush_o[0]),
    .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]), .stall_cnt(cnt_o[0]));

  pipe_hazard_unit #(.NREG_AW(5), .DEPTH(3), .LOAD_STAGE(2), .FWD_EN(0)) u1 (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wn(id_wn),
    .id_m2reg(id_m2reg), .redirect(redirect), .stall(stall_o[1]), .flush(flush_o[1]),
    .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]), .stall_cnt(cnt_o[1]));

  pipe_hazard_unit #(.NREG_AW(5), .DEPTH(5), .LOAD_STAGE(3), .FWD_EN(1)) u2 (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wn(id_wn),
    .id_m2reg(id_m2reg), .redirect(redirect), .stall(stall_o[2]), .flush(flush_o[2]),
    .fwd_a(fwd_a_o[2]), .fwd_b(fwd_b_o[2]), .stall_cnt(cnt_o[2]));

  // Reference model: per configuration, a queue of in-flight writers, youngest at index 0.
  typedef struct {
    bit       v;
    bit [4:0] wn;
    bit       ld;
  } ent_t;

  ent_t     pipe [NC][$];
  bit       known = 1'b0;
  bit       es  [NC];
  bit [2:0] ea  [NC];
  bit [2:0] eb  [NC];
  int       ecnt[NC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int youngest(int c, bit [4:0] s, bit use_s);
    if (!(id_valid && use_s) || s == 5'd0) return 0;
    for (int i = 0; i < CD[c]; i++)
      if (pipe[c][i].v && pipe[c][i].wn == s) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      pipe[c].delete();
      for (int i = 0; i < CD[c]; i++) pipe[c].push_back('{1'b0, 5'd0, 1'b0});
      ecnt[c] = 0;
    end
    known = 1'b1;
  endtask

  // Compute expectations from current inputs and compare, without waiting for time.
  task automatic eval_now();
    int ka, kb;
    bit s;
    if (!known) return;
    for (int c = 0; c < NC; c++) begin
      ka = youngest(c, id_rs, id_use_rs);
      kb = youngest(c, id_rt, id_use_rt);
      if (CFW[c] != 0) begin
        s = (ka > 0 && pipe[c][ka-1].ld && ka < CLS[c]) || (kb > 0 && pipe[c][kb-1].ld && kb < CLS[c]);
        ea[c] = 3'(ka);
        eb[c] = 3'(kb);
      end else begin
        s = (ka > 0 && ka < CD[c]) || (kb > 0 && kb < CD[c]);
        ea[c] = 3'd0;
        eb[c] = 3'd0;
      end
      es[c] = s && !redirect;
      check($sformatf("c%0d stall", c), 32'(stall_o[c]), 32'(es[c]));
      check($sformatf("c%0d flush", c), 32'(flush_o[c]), 32'(redirect));
      check($sformatf("c%0d fwd_a", c), 32'(fwd_a_o[c]), 32'(ea[c]));
      check($sformatf("c%0d fwd_b", c), 32'(fwd_b_o[c]), 32'(eb[c]));
      check($sformatf("c%0d stall_cnt", c), 32'(cnt_o[c]), 32'(ecnt[c]));
    end
  endtask

  task automatic eval();
    @(negedge clk);
    eval_now();
  endtask

  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (clrn) model_reset();
    else if (known) begin
      for (int c = 0; c < NC; c++) begin
        if (!es[c] && !redirect) e = '{id_valid && id_wreg && id_wn != 5'd0, id_wn, id_m2reg};
        else e = '{1'b0, 5'd0, 1'b0};
        pipe[c].push_front(e);
        void'(pipe[c].pop_back());
        if (es[c] && ecnt[c] != 65535) ecnt[c]++;
      end
    end
    #1;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                        input bit urt, input bit wr, input bit [4:0] wn, input bit m2);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_wn = wn; id_m2reg = m2;
  endtask

  task automatic step();
    eval();
    advance();
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    clrn = 1'b1;
    redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    clrn = 1'b0;
    eval();
    check("reset stall", 32'(stall_o[0]), 32'd0);
    check("reset fwd_a", 32'(fwd_a_o[0]), 32'd0);
    check("reset stall_cnt", 32'(cnt_o[0]), 32'd0);
    advance();

    // ALU chain: add r3; sub r4,r3,r3; then another reader of r3.
    set_id(1, 1, 2, 1, 1, 1, 3, 0); step();
    set_id(1, 3, 3, 1, 1, 1, 4, 0); eval();
    check("alu fwd_a k1", 32'(fwd_a_o[0]), 32'd1);
    check("alu fwd_b k1", 32'(fwd_b_o[0]), 32'd1);
    check("alu no stall", 32'(stall_o[0]), 32'd0);
    advance();
    set_id(1, 3, 0, 1, 0, 1, 5, 0); eval();
    check("alu fwd_a k2", 32'(fwd_a_o[0]), 32'd2);
    advance();
    drain();

    // Load-use: lw r5,0(r1); add r6,r5,r1.
    set_id(1, 1, 0, 1, 0, 1, 5, 1); step();
    set_id(1, 5, 1, 1, 1, 1, 6, 0); eval();
    check("ldu stall", 32'(stall_o[0]), 32'd1);
    check("ldu fwd_a during stall", 32'(fwd_a_o[0]), 32'd1);
    advance();
    eval();
    check("ldu released", 32'(stall_o[0]), 32'd0);
    check("ldu fwd_a k2", 32'(fwd_a_o[0]), 32'd2);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); eval();
    check("ldu stall_cnt", 32'(cnt_o[0]), 32'd1);
    advance();
    drain();

    // Register zero is never forwarded.
    set_id(1, 1, 2, 1, 1, 1, 0, 0); step();
    set_id(1, 0, 0, 1, 1, 1, 8, 0); eval();
    check("r0 fwd_a", 32'(fwd_a_o[0]), 32'd0);
    check("r0 fwd_b", 32'(fwd_b_o[0]), 32'd0);
    check("r0 no stall nofwd", 32'(stall_o[1]), 32'd0);
    advance();
    drain();

    // Youngest wins: r7 written in stages 1 and 3.
    set_id(1, 1, 2, 1, 1, 1, 7, 0); step();
    set_id(1, 1, 2, 1, 1, 1, 9, 0); step();
    set_id(1, 1, 2, 1, 1, 1, 7, 0); step();
    set_id(1, 7, 0, 1, 0, 1, 11, 0); eval();
    check("youngest c0", 32'(fwd_a_o[0]), 32'd1);
    check("youngest c2", 32'(fwd_a_o[2]), 32'd1);
    advance();
    drain();

    // No-forwarding interlock, after a fresh reset so the counter starts at 0.
    clrn = 1'b1; step(); clrn = 1'b0;
    set_id(1, 1, 1, 1, 1, 1, 2, 0); step();
    set_id(1, 2, 0, 1, 0, 1, 10, 0); eval();
    check("nofwd stall 1", 32'(stall_o[1]), 32'd1);
    check("nofwd fwd_a", 32'(fwd_a_o[1]), 32'd0);
    advance(); eval();
    check("nofwd stall 2", 32'(stall_o[1]), 32'd1);
    advance(); eval();
    check("nofwd released", 32'(stall_o[1]), 32'd0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); eval();
    check("nofwd stall_cnt", 32'(cnt_o[1]), 32'd2);
    advance();
    drain();

    // Redirect during a load-use stall.
    set_id(1, 1, 0, 1, 0, 1, 5, 1); step();
    set_id(1, 5, 1, 1, 1, 1, 6, 0); eval();
    check("redir pre stall", 32'(stall_o[0]), 32'd1);
    redirect = 1'b1; #1; eval_now();
    check("redir flush", 32'(flush_o[0]), 32'd1);
    check("redir stall", 32'(stall_o[0]), 32'd0);
    advance();
    redirect = 1'b0;
    set_id(1, 5, 6, 1, 1, 1, 12, 0); eval();
    check("redir entry1 empty", 32'(fwd_b_o[0]), 32'd0);
    check("redir older kept", 32'(fwd_a_o[0]), 32'd2);
    check("redir stall_cnt", 32'(cnt_o[0]), 32'd0);
    advance();
    drain();

    // Reset in the middle of a load-use stall.
    set_id(1, 1, 0, 1, 0, 1, 5, 1); step();
    set_id(1, 5, 1, 1, 1, 1, 6, 0); eval();
    check("rst pre stall", 32'(stall_o[0]), 32'd1);
    clrn = 1'b1; #1; eval_now();
    advance();
    clrn = 1'b0; eval();
    check("rst drops stall", 32'(stall_o[0]), 32'd0);
    check("rst clears fwd", 32'(fwd_a_o[0]), 32'd0);
    advance();

    // Random traffic; a stalled instruction is usually held in ID.
    for (int n = 0; n < 3000; n++) begin
      if (!(es[0] && $urandom_range(9) < 8)) begin
        set_id(bit'($urandom_range(9) < 8), 5'($urandom_range(7)), 5'($urandom_range(7)),
               bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(3) != 0),
               5'($urandom_range(7)), bit'($urandom_range(2) == 0));
      end
      redirect = ($urandom_range(19) == 0);
      clrn = ($urandom_range(199) == 0);
      step();
    end
    clrn = 1'b0;
    redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
